seg7_scan_decoder: RTL

- Capture-side counterpart of the hex-to-7-segment encoder.
- Samples a time-multiplexed 7-segment display bus (one-hot digit select plus segment lines), waits for each digit's pattern to be stable, then decodes it back to a hex nibble.
- Used by the debug/observation path to read back what the display shows, as a registered hex vector with per-digit valid/error flags.

---
 rtl/seg7_scan_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - captures a multiplexed 7-segment bus and decodes each stable digit back to hex
// Optional decimal-point capture is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_decoder #(
  parameter int DIGITS        = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic [6:0]            seg_in,
`ifdef SEG7_SCAN_DP_EN
  input  logic                  dp_in,
  output logic [DIGITS-1:0]     dp_vec,
`endif
  output logic [DIGITS*4-1:0]   hex_vec,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     seg_err,
  output logic                  upd
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
`ifdef SEG7_SCAN_DP_EN
  localparam int SW = DIGITS + 8;
`else
  localparam int SW = DIGITS + 7;
`endif

  typedef enum logic {TRACK, HELD} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       prev;
  logic [SW-1:0]       sample;
  logic [CW-1:0]       cnt_next;
  logic                one_hot;
  logic                same;
  logic                advance;
  logic                reached;
  logic [4:0]          dec;
  logic [DIGITS*4-1:0] hex_nxt;
  logic [DIGITS-1:0]   valid_nxt;
  logic [DIGITS-1:0]   err_nxt;
  logic                changed;

  // Returns {hit, nibble}; hit=0 means the pattern is blank or not a hex glyph.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = {1'b1, 4'h0};
      7'h06: decode = {1'b1, 4'h1};
      7'h5B: decode = {1'b1, 4'h2};
      7'h4F: decode = {1'b1, 4'h3};
      7'h66: decode = {1'b1, 4'h4};
      7'h6D: decode = {1'b1, 4'h5};
      7'h7D: decode = {1'b1, 4'h6};
      7'h07: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h6F: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h7C: decode = {1'b1, 4'hB};
      7'h58: decode = {1'b1, 4'hC};
      7'h5E: decode = {1'b1, 4'hD};
      7'h79: decode = {1'b1, 4'hE};
      7'h71: decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

`ifdef SEG7_SCAN_DP_EN
  logic [DIGITS-1:0] dp_nxt;
  assign sample = {dp_in, dig_sel, seg_in};
`else
  assign sample = {dig_sel, seg_in};
`endif

  assign one_hot  = $onehot(dig_sel);
  assign same     = (sample == prev);
  assign cnt_next = same ? cnt + CW'(1) : CW'(1);
  assign reached  = (cnt_next == CW'(STABLE_CYCLES));
  // A held pattern only re-enters counting once the sample changes.
  assign advance  = one_hot && (!same || state == TRACK);
  assign dec      = decode(seg_in);

  always_comb begin
    hex_nxt   = hex_vec;
    valid_nxt = digit_valid;
    err_nxt   = seg_err;
`ifdef SEG7_SCAN_DP_EN
    dp_nxt    = dp_vec;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_sel[i]) begin
        if (dec[4]) begin
          hex_nxt[i*4 +: 4] = dec[3:0];
          valid_nxt[i]      = 1'b1;
          err_nxt[i]        = 1'b0;
        end else begin
          valid_nxt[i] = 1'b0;
          err_nxt[i]   = (seg_in != 7'h00);
        end
`ifdef SEG7_SCAN_DP_EN
        dp_nxt[i] = dp_in;
`endif
      end
    end
  end

`ifdef SEG7_SCAN_DP_EN
  assign changed = (hex_nxt != hex_vec) || (valid_nxt != digit_valid) || (dp_nxt != dp_vec);
`else
  assign changed = (hex_nxt != hex_vec) || (valid_nxt != digit_valid);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= TRACK;
      cnt         <= '0;
      prev        <= '0;
      hex_vec     <= '0;
      digit_valid <= '0;
      seg_err     <= '0;
      upd         <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp_vec      <= '0;
`endif
    end else begin
      prev <= sample;
      upd  <= 1'b0;
      if (!one_hot) begin
        state <= TRACK;
        cnt   <= '0;
      end else if (advance) begin
        cnt <= cnt_next;
        if (reached) begin
          state       <= HELD;
          hex_vec     <= hex_nxt;
          digit_valid <= valid_nxt;
          seg_err     <= err_nxt;
          upd         <= changed;
`ifdef SEG7_SCAN_DP_EN
          dp_vec      <= dp_nxt;
`endif
        end else begin
          state <= TRACK;
        end
      end
    end
  end

endmodule
